// File: rtl/bitstream_receiver.sv
// bitstream_receiver
//   Oversampling serial frame receiver. The line idles low; a frame is a
//   high start bit, DATALEN payload bits sent MSB first, then a low stop bit.
//   Each bit period is CLK_DIV clk cycles. Each sample is a 3-cycle majority
//   vote of the synchronized line, taken at the centre of the bit.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous, active-high reset
//   en         : receive enable; low forces IDLE and abandons any frame
//   bitin      : asynchronous serial line
//   dataout    : last good payload
//   data_valid : one-cycle pulse when dataout updates
//   frame_err  : one-cycle pulse on a bad (high) stop bit
//   busy       : high while a frame is being received (START/DATA/STOP)
//   bit_cnt    : payload bits received in the current frame
module bitstream_receiver #(
    parameter int DATALEN = 128,
    parameter int CNTLEN  = 8,
    parameter int CLK_DIV = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               bitin,
    output logic [DATALEN-1:0] dataout,
    output logic               data_valid,
    output logic               frame_err,
    output logic               busy,
    output logic [CNTLEN-1:0]  bit_cnt
);

    localparam int PHASE_W = $clog2(CLK_DIV);
    localparam logic [PHASE_W-1:0] HALF_LAST = PHASE_W'(CLK_DIV / 2 - 1);
    localparam logic [PHASE_W-1:0] FULL_LAST = PHASE_W'(CLK_DIV - 1);
    localparam logic [CNTLEN-1:0]  BIT_LAST  = CNTLEN'(DATALEN - 1);

    typedef enum logic [2:0] {IDLE, ARMED, START, DATA, STOP} state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 sync_p0;
    logic                 sync_p1;   // synchronized line (bs)
    logic                 hist_p2;   // bs one cycle ago
    logic                 hist_p3;   // bs two cycles ago
    logic [PHASE_W-1:0]   phase;
    logic [DATALEN-1:0]   shreg;
    logic                 sample_pt;
    logic                 rise;
    logic                 vote;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Stage 0/1: two-flop synchronizer; stage 2/3: history for edge and vote
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            hist_p2 <= 1'b0;
            hist_p3 <= 1'b0;
        end else begin
            sync_p0 <= bitin;
            sync_p1 <= sync_p0;
            hist_p2 <= sync_p1;
            hist_p3 <= hist_p2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        sample_pt = 1'b0;
        busy      = 1'b0;
        rise      = sync_p1 & ~hist_p2;
        vote      = maj3(sync_p1, hist_p2, hist_p3);
        case (state)
            IDLE:  state_nxt = ARMED;
            ARMED: if (rise) state_nxt = START;
            START: begin
                busy      = 1'b1;
                sample_pt = (phase == HALF_LAST);
                // A start bit that does not survive the vote was a glitch
                if (sample_pt) state_nxt = vote ? DATA : ARMED;
            end
            DATA: begin
                busy      = 1'b1;
                sample_pt = (phase == FULL_LAST);
                if (sample_pt && bit_cnt == BIT_LAST) state_nxt = STOP;
            end
            STOP: begin
                busy      = 1'b1;
                sample_pt = (phase == FULL_LAST);
                if (sample_pt) state_nxt = ARMED;
            end
            default: state_nxt = IDLE;
        endcase
        if (!en) state_nxt = IDLE;
    end

    // Phase/bit counters, shift register and result pulses. Every sample
    // action is gated by en so an abandoned frame never produces a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase      <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            dataout    <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (state == ARMED && rise) begin
                phase <= '0;
                if (en) bit_cnt <= '0;
            end else if (sample_pt) begin
                phase <= '0;
            end else if (busy) begin
                phase <= phase + PHASE_W'(1);
            end
            if (en && sample_pt && state == DATA) begin
                shreg   <= {shreg[DATALEN-2:0], vote};
                bit_cnt <= bit_cnt + CNTLEN'(1);
            end
            if (en && sample_pt && state == STOP) begin
                if (!vote) begin
                    dataout    <= shreg;
                    data_valid <= 1'b1;
                end else begin
                    frame_err  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/bitstream_receiver.md
BITSTREAM_RECEIVER -- requirements
Module: bitstream_receiver

Interface
REQ-001 SHALL have parameter DATALEN, default 128, meaning frame payload width in bits.
REQ-002 SHALL have parameter CNTLEN, default 8, meaning bit-counter width; 2^CNTLEN SHALL be greater than DATALEN.
REQ-003 SHALL have parameter CLK_DIV, default 32, meaning clk cycles per bit period; it SHALL be even and at least 4.
REQ-004 SHALL have port clk, input, 1, meaning the single clock: ant_clk domain, all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset: synchronous, active-high.
REQ-006 SHALL have port en, input, 1, meaning receive enable; low forces IDLE.
REQ-007 SHALL have port bitin, input, 1, meaning asynchronous serial line.
REQ-008 SHALL have port dataout, output, DATALEN, meaning last good payload, MSB received first.
REQ-009 SHALL have port data_valid, output, 1, meaning one-cycle pulse when dataout updates.
REQ-010 SHALL have port frame_err, output, 1, meaning one-cycle pulse on bad stop bit.
REQ-011 SHALL have port busy, output, 1, meaning high in START, DATA and STOP states.
REQ-012 SHALL have port bit_cnt, output, CNTLEN, meaning payload bits received in the current frame.

Function
REQ-013 Frame format: start bit 1, DATALEN payload bits MSB first, stop bit 0; line idles at 0.
REQ-014 bitin SHALL pass a 2-flop synchronizer; bs denotes its output; all decisions use bs only.
REQ-015 Sample value SHALL be the majority of bs over the 3 consecutive cycles ending at the sample point.
REQ-016 FSM states: IDLE, ARMED, START, DATA, STOP.
REQ-017 IDLE SHALL go to ARMED in the cycle after en is sampled high.
REQ-018 ARMED: on a rising edge of bs (bs=1 with previous bs=0), SHALL clear the phase counter and go to START; a line already high on arming SHALL NOT start a frame.
REQ-019 START: the sample point SHALL be CLK_DIV/2 cycles after the edge cycle.
REQ-020 START: sample 1 SHALL go to DATA; sample 0 (glitch) SHALL return to ARMED with no pulse.
REQ-021 DATA: each sample point SHALL be exactly CLK_DIV cycles after the previous one.
REQ-022 DATA: each sample SHALL shift into an internal shift register from the LSB side and increment bit_cnt.
REQ-023 DATA: after bit DATALEN is sampled, SHALL go to STOP.
REQ-024 STOP: the sample point SHALL be CLK_DIV cycles after the last data sample.
REQ-025 STOP, sample 0: SHALL load dataout from the shift register and assert data_valid in the cycle after the sample point.
REQ-026 STOP, sample 1: SHALL assert frame_err in the cycle after the sample point and leave dataout unchanged.
REQ-027 STOP SHALL then return to ARMED; bit_cnt SHALL clear on entry to START.
REQ-028 data_valid and frame_err SHALL never be asserted together and SHALL each last exactly one cycle.
REQ-029 Deasserting en in any state SHALL go to IDLE on the next cycle, abandon the frame and emit no pulse; dataout SHALL be retained.
REQ-030 A new start edge SHALL be honoured as early as the first cycle after returning to ARMED.
REQ-031 Phase and bit counters SHALL NOT wrap within a frame; the phase counter width SHALL be ceil(log2(CLK_DIV)).

Reset
REQ-032 rst high SHALL, on the next clk edge, force IDLE; dataout=0; data_valid=0; frame_err=0; busy=0; bit_cnt=0; shift register=0; synchronizer flops=0.
REQ-033 rst SHALL take priority over en and any in-progress frame.
REQ-034 After rst deasserts, the block SHALL behave as if en had just been sampled.

Verification
REQ-035 en=1, send start, 128'hDEADBEEF_01234567_89ABCDEF_0F1E2D3C, stop 0 at CLK_DIV=32 -> one data_valid pulse at the stated cycle after the stop sample; dataout equals the payload; frame_err stays 0.
REQ-036 Same frame with stop bit 1 -> one frame_err pulse; dataout keeps its previous value; no data_valid.
REQ-037 bitin 1-cycle high glitch while ARMED -> START entered, then back to ARMED; busy high for about CLK_DIV/2 cycles; no pulses.
REQ-038 Single-cycle inverted bitin spikes at every data sample point -> majority vote rejects them; correct payload.
REQ-039 rst pulsed at bit 60 of a frame, then a full frame 128'h1 -> all outputs 0 after reset; the second frame is received correctly.
REQ-040 en dropped at bit 100, raised again, then two back-to-back frames (0 idle bits between stop and next start) -> no pulse for the aborted frame; two data_valid pulses with correct dataout.
